// File: rtl/shift_fma_sliced_norm_shifter.sv
// Normalisation shifter for the tiny FMA datapath: sum_shifted = sum << norm_shamt,
// built from a single slice-wide shifter that ORs one slice per cycle into an accumulator.
module shift_fma_sliced_norm_shifter #(
  parameter int unsigned PRECISION_BITS     = 24,
  parameter int unsigned SHIFT_AMOUNT_WIDTH = 7,
  parameter int unsigned NUM_SLICES         = 3,
  parameter int unsigned TAG_WIDTH          = 4,
  localparam int unsigned SUM_WIDTH         = 3 * PRECISION_BITS + 4,
  localparam int unsigned OUT_WIDTH         = 4 * PRECISION_BITS + 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [SUM_WIDTH-1:0]          sum_i,
  input  logic [SHIFT_AMOUNT_WIDTH-1:0] norm_shamt_i,
  input  logic [TAG_WIDTH-1:0]          tag_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [OUT_WIDTH-1:0]          sum_shifted_o,
  output logic [TAG_WIDTH-1:0]          tag_o,
  output logic                          busy_o
);

  localparam int unsigned SLICE_WIDTH = (SUM_WIDTH + NUM_SLICES - 1) / NUM_SLICES;
  localparam int unsigned PAD_WIDTH   = NUM_SLICES * SLICE_WIDTH;
  localparam int unsigned CNT_WIDTH   = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  // Wide enough for max shamt plus the largest slice offset, so the sum never wraps.
  localparam int unsigned EFF_WIDTH   = $clog2((1 << SHIFT_AMOUNT_WIDTH) + PAD_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_SLICES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                        state_q;
  logic [CNT_WIDTH-1:0]          cnt_q;
  logic [PAD_WIDTH-1:0]          sum_q;
  logic [SHIFT_AMOUNT_WIDTH-1:0] shamt_q;

  logic [SLICE_WIDTH-1:0] slice_c;
  logic [EFF_WIDTH-1:0]   eff_shamt_c;
  logic [OUT_WIDTH-1:0]   slice_shifted_c;
  logic                   accept_c;

  assign in_ready_o = (state_q == IDLE) || (state_q == DONE && out_ready_i);
  assign accept_c   = in_valid_i && in_ready_o && !flush_i;

  // Slice select and the single slice-wide shifter.
  always_comb begin
    slice_c = '0;
    for (int unsigned k = 0; k < NUM_SLICES; k++) begin
      if (cnt_q == CNT_WIDTH'(k)) slice_c = sum_q[k*SLICE_WIDTH +: SLICE_WIDTH];
    end
    eff_shamt_c     = EFF_WIDTH'(shamt_q) + EFF_WIDTH'(cnt_q) * EFF_WIDTH'(SLICE_WIDTH);
    slice_shifted_c = OUT_WIDTH'(slice_c) << eff_shamt_c;
  end

  // Control FSM; sum_shifted_o doubles as the accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sum_q         <= '0;
      shamt_q       <= '0;
      sum_shifted_o <= '0;
      tag_o         <= '0;
      out_valid_o   <= 1'b0;
      busy_o        <= 1'b0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        SHIFT: begin
          sum_shifted_o <= sum_shifted_o | slice_shifted_c;
          if (cnt_q == LAST_CNT) begin
            state_q     <= DONE;
            out_valid_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        DONE: begin
          if (out_ready_i && !in_valid_i) begin
            state_q     <= IDLE;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
      // A new operation may start from IDLE or directly out of DONE.
      if (accept_c) begin
        state_q       <= SHIFT;
        cnt_q         <= '0;
        sum_q         <= PAD_WIDTH'(sum_i);
        shamt_q       <= norm_shamt_i;
        tag_o         <= tag_i;
        sum_shifted_o <= '0;
        out_valid_o   <= 1'b0;
        busy_o        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_fma_sliced_norm_shifter.sv
// Scoreboard bench for shift_fma_sliced_norm_shifter with hand-computed directed vectors.
module tb_shift_fma_sliced_norm_shifter;

  localparam int unsigned SW = 76;
  localparam int unsigned OW = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] sum = '0;
  logic [6:0]    shamt = '0;
  logic [3:0]    tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] sum_shifted;
  logic [3:0]    tag_out;
  logic          busy;

  shift_fma_sliced_norm_shifter dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .sum_i(sum), .norm_shamt_i(shamt), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_shifted_o(sum_shifted), .tag_o(tag_out), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    tag;
    logic [OW-1:0] data;
  } exp_t;

  typedef struct {
    logic [SW-1:0] s;
    logic [6:0]    sh;
    logic [OW-1:0] e;
  } vec_t;

  exp_t sb[$];
  int   out_times[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   out_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one operation, wait (bounded) for acceptance, optionally record its expected result.
  task automatic issue(input logic [SW-1:0] s, input logic [6:0] sh, input logic [3:0] t,
                       input logic [OW-1:0] e, input bit push);
    int n = 0;
    logic acc;
    in_valid = 1'b1; sum = s; shamt = sh; tag = t;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 128'(0), 128'(1));
    else if (push) sb.push_back('{tag: t, data: e});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tick(1);
    check("drain", 128'(sb.size()), 128'(0));
  endtask

  // Monitor: compare every delivered result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        out_count++;
        out_times.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_output", 128'(sum_shifted), 128'(0) - 128'(1));
        end else begin
          e = sb.pop_front();
          check("result_data", 128'(sum_shifted), 128'(e.data));
          check("result_tag", 128'(tag_out), 128'(e.tag));
        end
      end
    end
  end

  initial begin
    vec_t vecs[9];
    int n;
    int cnt_before;
    logic [SW-1:0] ones = '1;

    vecs[0] = '{s: ones,              sh: 7'd24,  e: {ones, 24'h0}};
    vecs[1] = '{s: SW'(1) << 75,      sh: 7'd24,  e: OW'(1) << 99};
    vecs[2] = '{s: SW'(1) << 75,      sh: 7'd25,  e: '0};
    vecs[3] = '{s: SW'(1) << 75,      sh: 7'd127, e: '0};
    vecs[4] = '{s: SW'(76'hABC),      sh: 7'd4,   e: OW'(100'hABC0)};
    vecs[5] = '{s: SW'(1) << 26,      sh: 7'd73,  e: OW'(1) << 99};
    vecs[6] = '{s: SW'(1) << 52,      sh: 7'd46,  e: OW'(1) << 98};
    vecs[7] = '{s: SW'(1),            sh: 7'd99,  e: OW'(1) << 99};
    vecs[8] = '{s: SW'(1),            sh: 7'd100, e: '0};

    // Reset state
    #2;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_sum_shifted", 128'(sum_shifted), 128'(0));
    check("rst_tag", 128'(tag_out), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Latency: out_valid exactly 3 cycles after the accepting edge
    out_ready = 1'b1;
    issue(SW'(1), 7'd0, 4'd1, OW'(1), 1'b1);
    check("busy_after_accept", 128'(busy), 128'(1));
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!out_valid && n < 10);
    check("latency", 128'(n), 128'(3));
    wait_drain();

    // Directed arithmetic vectors, including shift boundaries
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].s, vecs[i].sh, 4'(i + 2), vecs[i].e, 1'b1);
      wait_drain();
    end

    // Back-to-back: one result every 4 cycles, in order
    out_times.delete();
    for (int t = 1; t <= 3; t++) issue(SW'(t), 7'd0, 4'(t), OW'(t), 1'b1);
    wait_drain();
    check("b2b_count", 128'(out_times.size()), 128'(3));
    if (out_times.size() == 3) begin
      check("b2b_spacing_1", 128'(out_times[1] - out_times[0]), 128'(4));
      check("b2b_spacing_2", 128'(out_times[2] - out_times[1]), 128'(4));
    end

    // Output stall: everything held for 5 cycles
    out_ready = 1'b0;
    issue(SW'(5), 7'd3, 4'd12, OW'(40), 1'b1);
    n = 0;
    while (!out_valid && n < 10) begin
      tick(1);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 128'(out_valid), 128'(1));
      check("stall_data", 128'(sum_shifted), 128'(40));
      check("stall_tag", 128'(tag_out), 128'(12));
      check("stall_in_ready", 128'(in_ready), 128'(0));
    end
    tick(1);
    out_ready = 1'b1;
    wait_drain();
    check("stall_released", 128'(out_valid), 128'(0));

    // Flush at cnt=1
    cnt_before = out_count;
    issue(SW'(76'hFF), 7'd0, 4'd14, '0, 1'b0);
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_busy", 128'(busy), 128'(0));
    check("flush_valid", 128'(out_valid), 128'(0));
    tick(6);
    check("flush_no_output", 128'(out_count), 128'(cnt_before));

    // Reset pulse at cnt=1
    issue(SW'(76'hFF), 7'd0, 4'd15, '0, 1'b0);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 128'(out_valid), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_sum", 128'(sum_shifted), 128'(0));
    check("midrst_tag", 128'(tag_out), 128'(0));
    tick(1);
    rst_n = 1'b1;
    tick(6);
    check("midrst_no_output", 128'(out_count), 128'(cnt_before));

    // Recovery operation
    issue(SW'(3), 7'd2, 4'd13, OW'(12), 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
